// File: rtl/ff_pkg.sv
// Shared types and constants for the flip-flop input conditioning blocks.
package ff_pkg;

  // The encoding is chosen so that bit 1 is the accepted level and the two
  // qualifying states are the ones where the bits differ.
  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b11,
    S_CHK_LOW  = 2'b10
  } cond_state_e;

  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/ff_sync_chain.sv
// Multi-stage flop synchroniser for a single asynchronous bit.
module ff_sync_chain
  import ff_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ff_input_conditioner.sv
// Synchronise, debounce and edge-detect an asynchronous input into clean
// level/rise/fall/busy controls for downstream flip-flop cells.
module ff_input_conditioner
  import ff_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  cond_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  ff_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_raw),
    .q   (s)
  );

  // NOTE: every signal written here is given a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!s) begin
          state_d = S_LOW;
        end else if (sample_en) begin
          if (cnt_q == CNT_LAST) state_d = S_HIGH;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_CHK_LOW;
          cnt_d   = '0;
        end
      end
      S_CHK_LOW: begin
        if (s) begin
          state_d = S_HIGH;
        end else if (sample_en) begin
          if (cnt_q == CNT_LAST) state_d = S_LOW;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register rather than one cycle later.
  always_comb begin
    level_d = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
    busy_d  = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
    rise_d  = (state_q == S_CHK_HIGH) && (state_d == S_HIGH);
    fall_d  = (state_q == S_CHK_LOW) && (state_d == S_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ff_input_conditioner.sv
// Directed self-checking bench for ff_input_conditioner with default parameters.
module tb_ff_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic in_raw;
  logic sample_en;
  logic level, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  ff_input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .sample_en (sample_en),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_raw    = 1'b0;
    sample_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_raw    = 1'b1;
    sample_en = 1'b1;
    tick();
    checks++;
    if ({level, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got lvl/rise/fall/busy=%b expected 0000",
               {level, rise, fall, busy});
    end
    tick();
    checks++;
    if ({level, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got lvl/rise/fall/busy=%b expected 0000",
               {level, rise, fall, busy});
    end
    in_raw = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_clean_rise();
    in_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (rise !== (e == 7) || level !== (e >= 7) || fall !== 1'b0 ||
          busy !== (e >= 3 && e <= 6)) begin
        errors++;
        $display("FAIL clean_rise edge %0d: got lvl=%b rise=%b fall=%b busy=%b expected lvl=%b rise=%b fall=0 busy=%b",
                 e, level, rise, fall, busy, e >= 7, e == 7, e >= 3 && e <= 6);
      end
    end
  endtask

  task automatic test_clean_fall();
    int falls = 0;
    in_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (fall === 1'b1) falls++;
      checks++;
      if (fall !== (e == 7) || level !== (e < 7) || rise !== 1'b0 ||
          busy !== (e >= 3 && e <= 6)) begin
        errors++;
        $display("FAIL clean_fall edge %0d: got lvl=%b rise=%b fall=%b busy=%b expected lvl=%b rise=0 fall=%b busy=%b",
                 e, level, rise, fall, busy, e < 7, e == 7, e >= 3 && e <= 6);
      end
    end
    checks++;
    if (falls != 1) begin
      errors++;
      $display("FAIL fall_count: got %0d expected 1", falls);
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 12; e++) begin
      in_raw = (e <= 3);
      tick();
      checks++;
      if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 ||
          busy !== (e >= 3 && e <= 5)) begin
        errors++;
        $display("FAIL glitch edge %0d: got lvl=%b rise=%b fall=%b busy=%b expected lvl=0 rise=0 fall=0 busy=%b",
                 e, level, rise, fall, busy, e >= 3 && e <= 5);
      end
    end
  endtask

  task automatic test_sample_en_gating();
    in_raw = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      sample_en = (e % 4 == 0);
      tick();
      checks++;
      if (rise !== (e == 16) || level !== (e >= 16) ||
          busy !== (e >= 3 && e <= 15)) begin
        errors++;
        $display("FAIL sample_en edge %0d: got lvl=%b rise=%b busy=%b expected lvl=%b rise=%b busy=%b",
                 e, level, rise, busy, e >= 16, e == 16, e >= 3 && e <= 15);
      end
    end
    sample_en = 1'b1;
  endtask

  task automatic test_reset_mid_qual();
    do_reset();
    in_raw = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    checks++;
    if (busy !== 1'b1 || level !== 1'b0) begin
      errors++;
      $display("FAIL midqual_busy: got busy=%b lvl=%b expected busy=1 lvl=0", busy, level);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({level, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midqual_reset: got lvl/rise/fall/busy=%b expected 0000",
               {level, rise, fall, busy});
    end
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (rise !== (e == 7) || level !== (e >= 7) || fall !== 1'b0) begin
        errors++;
        $display("FAIL release_rise edge %0d: got lvl=%b rise=%b fall=%b expected lvl=%b rise=%b fall=0",
                 e, level, rise, fall, e >= 7, e == 7);
      end
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      in_raw = k[0];
      tick();
      checks++;
      if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
        errors++;
        $display("FAIL bounce toggle %0d: got lvl=%b rise=%b fall=%b expected all 0",
                 k, level, rise, fall);
      end
    end
    in_raw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (rise === 1'b1) rises++;
      checks++;
      if (rise !== (e == 7) || fall !== 1'b0) begin
        errors++;
        $display("FAIL bounce_settle edge %0d: got rise=%b fall=%b expected rise=%b fall=0",
                 e, rise, fall, e == 7);
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_raw    = 1'b0;
    sample_en = 1'b1;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_sample_en_gating();
    test_reset_mid_qual();
    test_bounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_input_conditioner.md
Name: ff_input_conditioner

Overview:
Upstream conditioning stage for the flip-flop library cells (D/T/JK/SR). It takes an asynchronous, possibly bouncing input such as a push-button or external strobe, and synchronises it into clk. It debounces the input with a counted stability window. It produces a clean level plus single-cycle rise/fall pulses that drive T, J/K or S/R control inputs directly.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal range ≥2.
- DEBOUNCE_CYCLES, 4: number of qualifying samples the synchronised input must hold before a level change is accepted; legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. This is a localparam and cannot be overridden.

Ports:
- clk, input, 1: single clock; all logic is posedge clk.
- rst, input, 1: synchronous, active-low reset (rst==0 at a posedge resets).
- in_raw, input, 1: asynchronous raw input.
- sample_en, input, 1: qualifying-sample strobe; tie to 1 for per-cycle debounce.
- level, output, 1: debounced, registered level.
- rise, output, 1: one-cycle pulse when level goes 0→1.
- fall, output, 1: one-cycle pulse when level goes 1→0.
- busy, output, 1: high while a candidate transition is being qualified.

Behaviour:
- Reset (rst==0 at posedge):
  - All sync flops clear to 0.
  - FSM goes to LOW and cnt clears to 0.
  - level, rise, fall and busy are all 0.
  - Reset has priority over every other event, including mid-qualification.
- Synchroniser:
  - s = sync[SYNC_STAGES-1]. in_raw is never used outside the chain.
- FSM states:
  - LOW: level=0. If s==1, go to CHK_HIGH and set cnt=0.
  - CHK_HIGH: busy=1.
    - If s==0, go to LOW with no pulse (glitch rejected). This abort ignores sample_en.
    - Else if sample_en==1 and cnt==DEBOUNCE_CYCLES-1, go to HIGH.
    - Else if sample_en==1, cnt++.
    - Otherwise hold.
  - HIGH: level=1. If s==0, go to CHK_LOW and set cnt=0.
  - CHK_LOW: mirror of CHK_HIGH with polarity swapped. Abort returns to HIGH; completion goes to LOW.
- Outputs:
  - All outputs are registered.
  - rise=1 for exactly the one cycle following the CHK_HIGH→HIGH edge; level rises in the same cycle.
  - fall=1 for exactly the one cycle following the CHK_LOW→LOW edge; level falls in the same cycle.
  - rise and fall are never both 1. Neither can repeat without an intervening opposite transition.
  - busy is 0 in LOW and HIGH.
- Latency (sample_en=1, in_raw stable and meeting setup before edge 1):
  - The state change and pulse appear after rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - With defaults this is edge 7.
- sample_en gating:
  - Each sample_en=1 cycle in a CHK state counts one sample.
  - Latency therefore stretches by the number of sample_en=0 cycles.
- Counter:
  - cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - cnt is don't-care, but held, in LOW and HIGH.
- DEBOUNCE_CYCLES=1: the first qualifying sample in a CHK state completes the transition.
- Reset release with in_raw already 1:
  - The sync chain restarts from 0.
  - rise occurs SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge with rst==1.
- in_raw toggling faster than the debounce window produces no pulses and leaves level unchanged.

Decomposition:
- Package ff_pkg holds:
  - State encodings: LOW=2'b00, CHK_HIGH=2'b01, HIGH=2'b11, CHK_LOW=2'b10.
  - Reset polarity constant RST_ACTIVE=1'b0.
- Sub-module ff_sync_chain:
  - Parameter STAGES.
  - Ports: clk, rst (sync, active-low), d, q.
  - It is a chain of D flops that clears to 0 on reset.
  - It is instantiated once here and reusable by other blocks.

Test Plan:
- Clean rise, defaults, sample_en=1: in_raw 0→1 before edge 1 → rise=1 and level=1 after edge 7; rise=0 after edge 8; busy=1 after edges 3–6.
- Glitch rejection: in_raw high for 3 cycles, then low → level stays 0; rise and fall stay 0 throughout; busy pulses then returns to 0.
- Clean fall from HIGH: in_raw 1→0 → fall=1 and level=0 after edge 7; exactly one fall pulse.
- sample_en every 4th cycle, DEBOUNCE_CYCLES=4: in_raw rise → rise occurs only after the 4th qualifying sample_en cycle in CHK_HIGH; no pulse before it.
- Reset mid-qualification: assert rst=0 while in CHK_HIGH with cnt=2 → all outputs 0 and state LOW after that edge. Release with in_raw=1 → rise 7 edges after release.
- Bouncing input: 10 toggles at 1-cycle spacing, then stable 1 → exactly one rise pulse 7 edges after the last toggle; no fall pulses.
